div_seq16: RTL and testbench

Sequential restoring integer divider core behind the memory-mapped divider peripheral. It captures the two operand registers on a rising edge of `init` and iterates one quotient bit per clock. It then presents `{remainder, quotient}` on `result` with a sticky `done` flag that the peripheral's read mux returns to the CPU. One division in flight at a time; no pipelining.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 30 +++
 rtl/div_seq16.sv | 139 +++++++++++++
 tb/tb_div_seq16.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// The DIV_SIGNED_EN macro, when defined, selects two's-complement operands in div_seq16.
package div_pkg;

    // Default operand width of the divider core.
    localparam int DIV_WIDTH = 16;

    // Width of the iteration counter for the default operand width.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Controller states: capture, magnitude load, one bit per cycle, sign fix-up.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// The step shifts {rem, quo} left by one, then trial-subtracts the divisor from the
// widened remainder. When the result is non-negative, the difference is kept and a 1
// enters the quotient LSB.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // The remainder picks up the quotient MSB and is compared at WIDTH+1 bits.
    assign w_rem_sh = {rem, quo[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, divisor});

    // When the trial succeeds the true difference is below 2^WIDTH,
    // so a WIDTH-bit modular subtract is exact.
    assign w_diff   = w_rem_sh[WIDTH-1:0] - divisor;

    assign rem_next = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_seq16.sv
// Sequential restoring divider: captures operands on a rising edge of init,
// iterates one quotient bit per clock and presents {remainder, quotient}
// with a sticky done flag.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise the core is unsigned.
module div_seq16
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [WIDTH-1:0]     op_A,
    input  logic [WIDTH-1:0]     op_B,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);

    div_state_t         r_state;
    logic               r_init_q;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_done;
    logic               r_busy;

    logic               w_start;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // A division only starts on a 0->1 transition of the init level.
    assign w_start = init & ~r_init_q;

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // Magnitudes of the captured operands. 0x8000 maps to itself, which is the correct unsigned magnitude.
    assign w_mag_a = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_mag_b = r_b[WIDTH-1] ? -r_b : r_b;

    // The quotient truncates toward zero. The remainder follows the dividend's sign.
    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;
`else
    assign w_mag_a = r_a;
    assign w_mag_b = r_b;
    assign w_q_fix = r_quo;
    assign w_r_fix = r_rem;
`endif

    div_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .divisor  (r_div),
        .rem_next (w_rem_next),
        .quo_next (w_quo_next)
    );

    // Control FSM with registered outputs. Reset aborts any division in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_init_q <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_init_q <= init;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_a     <= op_A;
                        r_b     <= op_B;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_rem   <= '0;
                    r_quo   <= w_mag_a;
                    r_div   <= w_mag_b;
                    r_cnt   <= CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
                    r_neg_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_neg_r <= r_a[WIDTH-1];
`endif
                    r_state <= ITER;
                end
                ITER: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_result <= {w_r_fix, w_q_fix};
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule

// File: tb/tb_div_seq16.sv
// Directed bench for div_seq16. Each started division pushes its expected result onto a
// scoreboard queue. The expected value is popped and compared when done rises.
// Define DIV_SIGNED_EN to check the signed build.
module tb_div_seq16;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        init   = 1'b0;
    logic [15:0] op_A   = '0;
    logic [15:0] op_B   = '0;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int          tests  = 0;
    int          fails  = 0;
    int          cyc    = 0;
    bit          busy_gap;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    div_seq16 dut (
        .clk    (clk),
        .reset  (reset),
        .init   (init),
        .op_A   (op_A),
        .op_B   (op_B),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference division result as {remainder, quotient}.
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
        int q;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (b == 16'h0) begin
            q = (sa < 0) ? 1 : -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r[15:0], q[15:0]};
`else
        if (b == 16'h0) return {a, 16'hFFFF};
        return {a % b, a / b};
`endif
    endfunction

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!done && !busy) busy_gap = 1'b1;
    endtask

    // Produce a clean init rising edge. Return just after the start edge.
    task automatic do_start(input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] exp, input bit push);
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        op_A = a;
        op_B = b;
        init = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        cyc      = 0;
        busy_gap = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
    endtask

    // Wait (bounded) for done, then check latency, busy and the scoreboard head.
    task automatic wait_result(input string tag);
        logic [31:0] exp;
        while (!done && cyc < 40) tick();
        check({tag, "_latency"}, cyc, 18);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_busy_gap"}, busy_gap, 0);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, result, exp);
        end
        $display("[TB] %s A=%h B=%h result=%h cycles=%0d", tag, op_A, op_B, result, cyc);
    endtask

    initial begin
        int busy_seen;
        logic [15:0] ra;
        logic [15:0] rb;

        // Reset state
        #12;
        check("reset_result", result, 32'h0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic unsigned
        do_start(16'd100, 16'd7, 32'h0002_000E, 1);
        wait_result("basic");

        // Full range
        do_start(16'hFFFF, 16'h0001, 32'h0000_FFFF, 1);
        wait_result("full_a");
`ifdef DIV_SIGNED_EN
        do_start(16'h0005, 16'hFFFF, 32'h0000_FFFB, 1);
`else
        do_start(16'h0005, 16'hFFFF, 32'h0005_0000, 1);
`endif
        wait_result("full_b");

        // Divide by zero
        do_start(16'h1234, 16'h0000, 32'h1234_FFFF, 1);
        wait_result("div0");

        // init held high for 40 cycles: no further division
        busy_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (busy) busy_seen++;
        end
        check("hold_busy", busy_seen, 0);
        check("hold_done", done, 1);
        check("hold_result", result, 32'h1234_FFFF);

        // Second rising edge mid-division, with operand changes, is ignored
        do_start(16'd50000, 16'd123, model(16'd50000, 16'd123), 1);
        repeat (5) tick();
        check("mid_result_held", result, 32'h1234_FFFF);
        init = 1'b0;
        op_A = 16'h0001;
        op_B = 16'h0001;
        tick();
        init = 1'b1;
        tick();
        wait_result("retrig_mid");
        busy_seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (busy) busy_seen++;
        end
        check("retrig_no_second", busy_seen, 0);

        // Low-to-high after done starts a new division (done drop checked in do_start)
        do_start(16'd1000, 16'd7, model(16'd1000, 16'd7), 1);
        wait_result("restart");

        // Reset mid-operation
        do_start(16'd1000, 16'd3, 32'h0, 0);
        while (cyc < 9) tick();
        reset = 1'b0;
        init  = 1'b0;
        #1;
        check("abort_result", result, 32'h0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        do_start(16'd1000, 16'd3, 32'h0001_014D, 1);
        wait_result("after_abort");

`ifdef DIV_SIGNED_EN
        // Signed cases
        do_start(16'hFFF9, 16'h0002, 32'hFFFF_FFFD, 1);
        wait_result("s_m7_2");
        do_start(16'h0007, 16'hFFFE, 32'h0001_FFFD, 1);
        wait_result("s_7_m2");
        do_start(16'h8000, 16'hFFFF, 32'h0000_8000, 1);
        wait_result("s_ovf");
`endif

        // Random operands against the reference model
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 65535));
            do_start(ra, rb, model(ra, rb), 1);
            wait_result("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
